id_ex_stage_reg: RTL and testbench

- Pipeline register between the ID stage and the EXE stage of the 5-stage ARM core.
- Captures decoded instruction fields, register operands and the NZCV carry each cycle.
- Consumes the condition-check result. A failed condition turns the instruction into a bubble: all architectural side-effect controls are cleared.
- Supports hazard freeze and branch flush. Keeps a saturating count of condition-squashed instructions for debug.

---
 rtl/id_ex_stage_reg.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// id_ex_stage_reg
//
// Pipeline register between the ID and EXE stages of the 5-stage ARM core.
// Captures the decoded instruction fields, register operands and the carry
// flag every cycle. The instruction is squashed here when its condition
// fails, which clears every architectural side-effect control. Doing this
// here means a squashed S-instruction can never update the status register
// and a squashed branch can never redirect the PC. Hazard freeze and branch
// flush are supported. A saturating counter records how many valid
// instructions were squashed by a failed condition, for debug.
//
// Ports
//   clk, rst              core clock; synchronous active-high reset
//   freeze                hazard stall: hold every registered output
//   flush                 branch taken in EXE: load a bubble
//   valid_in              ID holds a real instruction
//   condition_is_met      condition-check result for the ID instruction
//   sr_in                 status register {N,Z,C,V}
//   pc_in                 PC+4 of the ID instruction
//   rn_val_in, rm_val_in  register operands
//   exe_cmd_in            ALU command
//   mem_r_en_in, mem_w_en_in, wb_en_in, s_in, b_in   control bits
//   imm_in                immediate operand flag
//   shift_operand_in      shifter operand
//   signed_imm_24_in      branch offset
//   dest_in, src1_in, src2_in   register indices
//   *_out                 registered copies of the inputs above
//   valid_out             EXE holds a live instruction
//   carry_out             registered C bit (sr_in[1])
//   squash_cnt            saturating count of condition-squashed instructions
// ---------------------------------------------------------------------------
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              valid_in,
    input  logic              condition_is_met,
    input  logic [3:0]        sr_in,
    input  logic [DATA_W-1:0] pc_in,
    input  logic [DATA_W-1:0] rn_val_in,
    input  logic [DATA_W-1:0] rm_val_in,
    input  logic [3:0]        exe_cmd_in,
    input  logic              mem_r_en_in,
    input  logic              mem_w_en_in,
    input  logic              wb_en_in,
    input  logic              s_in,
    input  logic              b_in,
    input  logic              imm_in,
    input  logic [11:0]       shift_operand_in,
    input  logic [23:0]       signed_imm_24_in,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        src1_in,
    input  logic [3:0]        src2_in,
    output logic [DATA_W-1:0] pc_out,
    output logic [DATA_W-1:0] rn_val_out,
    output logic [DATA_W-1:0] rm_val_out,
    output logic [3:0]        exe_cmd_out,
    output logic              mem_r_en_out,
    output logic              mem_w_en_out,
    output logic              wb_en_out,
    output logic              s_out,
    output logic              b_out,
    output logic              imm_out,
    output logic [11:0]       shift_operand_out,
    output logic [23:0]       signed_imm_24_out,
    output logic [3:0]        dest_out,
    output logic [3:0]        src1_out,
    output logic [3:0]        src2_out,
    output logic              valid_out,
    output logic              carry_out,
    output logic [CNT_W-1:0]  squash_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // A real instruction whose condition holds; only these may cause
    // architectural side effects downstream.
    logic live;
    assign live = valid_in & condition_is_met;

    // Counts only real instructions killed by their condition, not IF bubbles.
    logic squash_evt;
    assign squash_evt = valid_in & ~condition_is_met;

    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_out            <= '0;
            rn_val_out        <= '0;
            rm_val_out        <= '0;
            exe_cmd_out       <= '0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            s_out             <= 1'b0;
            b_out             <= 1'b0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            valid_out         <= 1'b0;
            carry_out         <= 1'b0;
            squash_cnt        <= '0;
        end else if (flush) begin
            // Bubble: everything cleared except the debug counter, which
            // keeps its history. Flush takes precedence over freeze.
            pc_out            <= '0;
            rn_val_out        <= '0;
            rm_val_out        <= '0;
            exe_cmd_out       <= '0;
            mem_r_en_out      <= 1'b0;
            mem_w_en_out      <= 1'b0;
            wb_en_out         <= 1'b0;
            s_out             <= 1'b0;
            b_out             <= 1'b0;
            imm_out           <= 1'b0;
            shift_operand_out <= '0;
            signed_imm_24_out <= '0;
            dest_out          <= '0;
            src1_out          <= '0;
            src2_out          <= '0;
            valid_out         <= 1'b0;
            carry_out         <= 1'b0;
        end else if (!freeze) begin
            // Data fields and register indices are captured even for a
            // squashed instruction; consumers qualify them with the enables.
            pc_out            <= pc_in;
            rn_val_out        <= rn_val_in;
            rm_val_out        <= rm_val_in;
            exe_cmd_out       <= exe_cmd_in;
            imm_out           <= imm_in;
            shift_operand_out <= shift_operand_in;
            signed_imm_24_out <= signed_imm_24_in;
            dest_out          <= dest_in;
            src1_out          <= src1_in;
            src2_out          <= src2_in;
            carry_out         <= sr_in[1];
            valid_out         <= live;
            mem_r_en_out      <= mem_r_en_in & live;
            mem_w_en_out      <= mem_w_en_in & live;
            wb_en_out         <= wb_en_in & live;
            s_out             <= s_in & live;
            b_out             <= b_in & live;
            if (squash_evt && (squash_cnt != '1)) begin
                squash_cnt <= squash_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Directed-vector bench for id_ex_stage_reg. The counter width is reduced to
// 4 bits so saturation is reached quickly. Inputs are driven 1 ns after the
// rising edge and outputs are sampled 1 ns after the following rising edge.
// ---------------------------------------------------------------------------
module tb_id_ex_stage_reg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk;
    logic              rst;
    logic              freeze;
    logic              flush;
    logic              valid_in;
    logic              condition_is_met;
    logic [3:0]        sr_in;
    logic [DATA_W-1:0] pc_in;
    logic [DATA_W-1:0] rn_val_in;
    logic [DATA_W-1:0] rm_val_in;
    logic [3:0]        exe_cmd_in;
    logic              mem_r_en_in;
    logic              mem_w_en_in;
    logic              wb_en_in;
    logic              s_in;
    logic              b_in;
    logic              imm_in;
    logic [11:0]       shift_operand_in;
    logic [23:0]       signed_imm_24_in;
    logic [3:0]        dest_in;
    logic [3:0]        src1_in;
    logic [3:0]        src2_in;

    logic [DATA_W-1:0] pc_out;
    logic [DATA_W-1:0] rn_val_out;
    logic [DATA_W-1:0] rm_val_out;
    logic [3:0]        exe_cmd_out;
    logic              mem_r_en_out;
    logic              mem_w_en_out;
    logic              wb_en_out;
    logic              s_out;
    logic              b_out;
    logic              imm_out;
    logic [11:0]       shift_operand_out;
    logic [23:0]       signed_imm_24_out;
    logic [3:0]        dest_out;
    logic [3:0]        src1_out;
    logic [3:0]        src2_out;
    logic              valid_out;
    logic              carry_out;
    logic [CNT_W-1:0]  squash_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;
    int exp_cnt      = 0;

    id_ex_stage_reg #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_dut (
        .clk              (clk),
        .rst              (rst),
        .freeze           (freeze),
        .flush            (flush),
        .valid_in         (valid_in),
        .condition_is_met (condition_is_met),
        .sr_in            (sr_in),
        .pc_in            (pc_in),
        .rn_val_in        (rn_val_in),
        .rm_val_in        (rm_val_in),
        .exe_cmd_in       (exe_cmd_in),
        .mem_r_en_in      (mem_r_en_in),
        .mem_w_en_in      (mem_w_en_in),
        .wb_en_in         (wb_en_in),
        .s_in             (s_in),
        .b_in             (b_in),
        .imm_in           (imm_in),
        .shift_operand_in (shift_operand_in),
        .signed_imm_24_in (signed_imm_24_in),
        .dest_in          (dest_in),
        .src1_in          (src1_in),
        .src2_in          (src2_in),
        .pc_out           (pc_out),
        .rn_val_out       (rn_val_out),
        .rm_val_out       (rm_val_out),
        .exe_cmd_out      (exe_cmd_out),
        .mem_r_en_out     (mem_r_en_out),
        .mem_w_en_out     (mem_w_en_out),
        .wb_en_out        (wb_en_out),
        .s_out            (s_out),
        .b_out            (b_out),
        .imm_out          (imm_out),
        .shift_operand_out(shift_operand_out),
        .signed_imm_24_out(signed_imm_24_out),
        .dest_out         (dest_out),
        .src1_out         (src1_out),
        .src2_out         (src2_out),
        .valid_out        (valid_out),
        .carry_out        (carry_out),
        .squash_cnt       (squash_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed,
                         input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are settled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_inputs();
        freeze           = 1'($urandom);
        flush            = 1'($urandom);
        valid_in         = 1'($urandom);
        condition_is_met = 1'($urandom);
        sr_in            = 4'($urandom);
        pc_in            = $urandom;
        rn_val_in        = $urandom;
        rm_val_in        = $urandom;
        exe_cmd_in       = 4'($urandom);
        mem_r_en_in      = 1'($urandom);
        mem_w_en_in      = 1'($urandom);
        wb_en_in         = 1'($urandom);
        s_in             = 1'($urandom);
        b_in             = 1'($urandom);
        imm_in           = 1'($urandom);
        shift_operand_in = 12'($urandom);
        signed_imm_24_in = 24'($urandom);
        dest_in          = 4'($urandom);
        src1_in          = 4'($urandom);
        src2_in          = 4'($urandom);
    endtask

    // Plain instruction template; callers override the fields they care about.
    task automatic set_instr(input logic [3:0] cmd, input logic [DATA_W-1:0] pc);
        freeze           = 1'b0;
        flush            = 1'b0;
        valid_in         = 1'b1;
        condition_is_met = 1'b1;
        sr_in            = 4'b0000;
        pc_in            = pc;
        rn_val_in        = 32'h0000_0005;
        rm_val_in        = 32'h0000_0007;
        exe_cmd_in       = cmd;
        mem_r_en_in      = 1'b0;
        mem_w_en_in      = 1'b0;
        wb_en_in         = 1'b0;
        s_in             = 1'b0;
        b_in             = 1'b0;
        imm_in           = 1'b0;
        shift_operand_in = 12'h000;
        signed_imm_24_in = 24'h000000;
        dest_in          = 4'd0;
        src1_in          = 4'd1;
        src2_in          = 4'd2;
    endtask

    initial begin
        // Reset held two cycles under random inputs, including flush/freeze.
        rst = 1'b1;
        randomize_inputs();
        step();
        randomize_inputs();
        step();
        check("rst_valid",   64'(valid_out),         64'd0);
        check("rst_wb_en",   64'(wb_en_out),         64'd0);
        check("rst_mem_w",   64'(mem_w_en_out),      64'd0);
        check("rst_pc",      64'(pc_out),            64'd0);
        check("rst_rn",      64'(rn_val_out),        64'd0);
        check("rst_exe_cmd", 64'(exe_cmd_out),       64'd0);
        check("rst_shift",   64'(shift_operand_out), 64'd0);
        check("rst_dest",    64'(dest_out),          64'd0);
        check("rst_src1",    64'(src1_out),          64'd0);
        check("rst_carry",   64'(carry_out),         64'd0);
        check("rst_cnt",     64'(squash_cnt),        64'd0);

        // Valid ADD, condition met.
        rst = 1'b0;
        set_instr(4'b0001, 32'h0000_0100);
        wb_en_in = 1'b1;
        dest_in  = 4'd3;
        step();
        check("add_valid",   64'(valid_out),   64'd1);
        check("add_wb_en",   64'(wb_en_out),   64'd1);
        check("add_dest",    64'(dest_out),    64'd3);
        check("add_exe_cmd", 64'(exe_cmd_out), 64'd1);
        check("add_pc",      64'(pc_out),      64'h100);
        check("add_rm",      64'(rm_val_out),  64'd7);
        check("add_cnt",     64'(squash_cnt),  64'd0);

        // ADDEQ with S set, condition fails: bubble, fields still captured.
        set_instr(4'b0001, 32'h0000_0104);
        wb_en_in         = 1'b1;
        s_in             = 1'b1;
        dest_in          = 4'd4;
        src1_in          = 4'd9;
        condition_is_met = 1'b0;
        step();
        exp_cnt = 1;
        check("cf_valid", 64'(valid_out),  64'd0);
        check("cf_wb_en", 64'(wb_en_out),  64'd0);
        check("cf_s",     64'(s_out),      64'd0);
        check("cf_dest",  64'(dest_out),   64'd4);
        check("cf_src1",  64'(src1_out),   64'd9);
        check("cf_cnt",   64'(squash_cnt), 64'(exp_cnt));

        // Failing branch must not redirect: b_out cleared.
        set_instr(4'b0000, 32'h0000_0108);
        b_in             = 1'b1;
        mem_r_en_in      = 1'b1;
        condition_is_met = 1'b0;
        signed_imm_24_in = 24'hABCDEF;
        step();
        exp_cnt = 2;
        check("cfb_b",     64'(b_out),             64'd0);
        check("cfb_mem_r", 64'(mem_r_en_out),      64'd0);
        check("cfb_imm24", 64'(signed_imm_24_out), 64'hABCDEF);
        check("cfb_cnt",   64'(squash_cnt),        64'(exp_cnt));

        // Load pc 0x10, then freeze 3 cycles with a failing instruction shown.
        set_instr(4'b0100, 32'h0000_0010);
        wb_en_in = 1'b1;
        step();
        check("frz_load_pc", 64'(pc_out), 64'h10);
        freeze           = 1'b1;
        pc_in            = 32'h0000_0014;
        condition_is_met = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("frz_pc",    64'(pc_out),     64'h10);
            check("frz_valid", 64'(valid_out),  64'd1);
            check("frz_cnt",   64'(squash_cnt), 64'(exp_cnt));
        end
        freeze           = 1'b0;
        condition_is_met = 1'b1;
        step();
        check("unfrz_pc",  64'(pc_out),     64'h14);
        check("unfrz_cnt", 64'(squash_cnt), 64'(exp_cnt));

        // Flush together with freeze on a valid STR, failing condition shown
        // so the counter must also stay put.
        set_instr(4'b0100, 32'h0000_0020);
        mem_w_en_in      = 1'b1;
        rn_val_in        = 32'h0000_00AA;
        rm_val_in        = 32'h0000_00BB;
        sr_in            = 4'b0010;
        imm_in           = 1'b1;
        shift_operand_in = 12'h5A5;
        dest_in          = 4'd7;
        flush            = 1'b1;
        freeze           = 1'b1;
        condition_is_met = 1'b0;
        step();
        check("fl_valid", 64'(valid_out),         64'd0);
        check("fl_mem_w", 64'(mem_w_en_out),      64'd0);
        check("fl_pc",    64'(pc_out),            64'd0);
        check("fl_rn",    64'(rn_val_out),        64'd0);
        check("fl_rm",    64'(rm_val_out),        64'd0);
        check("fl_shift", 64'(shift_operand_out), 64'd0);
        check("fl_imm",   64'(imm_out),           64'd0);
        check("fl_dest",  64'(dest_out),          64'd0);
        check("fl_carry", 64'(carry_out),         64'd0);
        check("fl_cnt",   64'(squash_cnt),        64'(exp_cnt));

        // Carry capture on ADC, then cleared by the next load.
        set_instr(4'b0101, 32'h0000_0024);
        wb_en_in = 1'b1;
        sr_in    = 4'b0010;
        step();
        check("adc_carry1", 64'(carry_out), 64'd1);
        sr_in = 4'b0000;
        step();
        check("adc_carry0", 64'(carry_out), 64'd0);

        // IF bubble with failing condition is not counted.
        set_instr(4'b0001, 32'h0000_0028);
        valid_in         = 1'b0;
        condition_is_met = 1'b0;
        wb_en_in         = 1'b1;
        step();
        check("bub_valid", 64'(valid_out),  64'd0);
        check("bub_wb_en", 64'(wb_en_out),  64'd0);
        check("bub_cnt",   64'(squash_cnt), 64'(exp_cnt));

        // 17 consecutive valid condition-fail loads: saturates at 15.
        set_instr(4'b0001, 32'h0000_002C);
        condition_is_met = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
            check("sat_cnt", 64'(squash_cnt), 64'(exp_cnt));
        end
        check("sat_final", 64'(squash_cnt), 64'd15);

        // A flush after saturation leaves the count alone.
        flush = 1'b1;
        step();
        check("sat_flush_cnt", 64'(squash_cnt), 64'd15);

        // Reset clears the counter again.
        flush = 1'b0;
        rst   = 1'b1;
        step();
        check("rst2_cnt", 64'(squash_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
